// File: rtl/ras_ckpt_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ras_ckpt_pkg                                                             |
// | Shared constants, the operation enum and helpers for the return stack.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package ras_ckpt_pkg;

    localparam int          RAS_DEFAULT_DEPTH  = 16;
    localparam int          RAS_DEFAULT_ADDR_W = 32;
    // Fetch falls back to this PC when a return is predicted on an empty stack.
    localparam logic [31:0] RAS_RESET_PC       = 32'h1C00_0000;

    typedef enum logic [2:0] {
        RAS_OP_IDLE     = 3'd0,
        RAS_OP_POP      = 3'd1,
        RAS_OP_PUSH     = 3'd2,
        RAS_OP_PUSH_POP = 3'd3,
        RAS_OP_RECOVER  = 3'd4
    } ras_op_e;

    // Checkpoint bundle is packed as {ckpt_top, ckpt_count, ckpt_ptr}.
    function automatic int ras_ckpt_bundle_w(input int depth, input int addr_w);
        return $clog2(depth) + ($clog2(depth) + 1) + addr_w;
    endfunction

    function automatic ras_op_e ras_decode_op(input logic push, input logic pop,
                                              input logic recover);
        if (recover)          return RAS_OP_RECOVER;
        else if (push && pop) return RAS_OP_PUSH_POP;
        else if (push)        return RAS_OP_PUSH;
        else if (pop)         return RAS_OP_POP;
        else                  return RAS_OP_IDLE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ras_ckpt_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ras_ckpt_if                                                              |
// | Predictor-side push/pop, checkpoint and recover bundle of the RAS.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface ras_ckpt_if
    import ras_ckpt_pkg::*;
#(
    parameter int DEPTH  = RAS_DEFAULT_DEPTH,
    parameter int ADDR_W = RAS_DEFAULT_ADDR_W
);
    localparam int PTR_W = $clog2(DEPTH);

    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] push_addr;
    logic [ADDR_W-1:0] top_addr;
    logic              top_valid;
    logic [PTR_W-1:0]  ckpt_ptr;
    logic [PTR_W:0]    ckpt_count;
    logic [ADDR_W-1:0] ckpt_top;
    logic              recover;
    logic [PTR_W-1:0]  recover_ptr;
    logic [PTR_W:0]    recover_count;
    logic [ADDR_W-1:0] recover_top;
    logic              overflow;

    modport master (
        output push, pop, push_addr, recover, recover_ptr, recover_count, recover_top,
        input  top_addr, top_valid, ckpt_ptr, ckpt_count, ckpt_top, overflow
    );

    modport slave (
        input  push, pop, push_addr, recover, recover_ptr, recover_count, recover_top,
        output top_addr, top_valid, ckpt_ptr, ckpt_count, ckpt_top, overflow
    );

endinterface
`default_nettype wire

// File: rtl/ras_ckpt_ptr_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ras_ptr_ctrl                                                             |
// | Priority encode plus pointer/count/overflow next-state and write select. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ras_ptr_ctrl
    import ras_ckpt_pkg::*;
#(
    parameter  int DEPTH = RAS_DEFAULT_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  wire logic             push,
    input  wire logic             pop,
    input  wire logic             recover,
    input  wire logic [PTR_W-1:0] recover_ptr,
    input  wire logic [CNT_W-1:0] recover_count,
    input  wire logic [PTR_W-1:0] ptr_q,
    input  wire logic [CNT_W-1:0] count_q,
    input  wire logic             overflow_q,
    output      logic [PTR_W-1:0] ptr_d,
    output      logic [CNT_W-1:0] count_d,
    output      logic             overflow_d,
    output      logic             wr_en,
    output      logic [PTR_W-1:0] wr_idx
);
    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

    ras_op_e op;

    always_comb begin
        op         = ras_decode_op(push, pop, recover);
        ptr_d      = ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        wr_en      = 1'b0;
        wr_idx     = ptr_q;
        case (op)
            RAS_OP_RECOVER: begin
                ptr_d      = recover_ptr;
                // Illegal occupancy from a corrupted checkpoint is clamped.
                count_d    = (recover_count > C_FULL) ? C_FULL : recover_count;
                overflow_d = 1'b0;
                wr_en      = 1'b1;
                wr_idx     = recover_ptr;
            end
            RAS_OP_PUSH_POP: begin
                wr_en = 1'b1;
                if (count_q == '0) count_d = CNT_W'(1);
            end
            RAS_OP_PUSH: begin
                ptr_d  = ptr_q + PTR_W'(1);
                wr_en  = 1'b1;
                wr_idx = ptr_q + PTR_W'(1);
                if (count_q == C_FULL) overflow_d = 1'b1;
                else                   count_d    = count_q + CNT_W'(1);
            end
            RAS_OP_POP: begin
                if (count_q != '0) begin
                    ptr_d   = ptr_q - PTR_W'(1);
                    count_d = count_q - CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ras_ckpt.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ras_ckpt                                                                 |
// | Circular return address stack with wrap-on-overflow and checkpointing.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ras_ckpt
    import ras_ckpt_pkg::*;
#(
    parameter  int DEPTH  = RAS_DEFAULT_DEPTH,
    parameter  int ADDR_W = RAS_DEFAULT_ADDR_W,
    localparam int PTR_W  = $clog2(DEPTH)
) (
    input  wire logic clk,
    input  wire logic rst_n,
    ras_ckpt_if.slave bus
);
    logic [ADDR_W-1:0] stack_q [DEPTH];
    logic [ADDR_W-1:0] stack_d [DEPTH];
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              wr_en;
    logic [PTR_W-1:0]  wr_idx;
    logic [ADDR_W-1:0] wr_data;

    ras_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr_ctrl (
        .push          (bus.push),
        .pop           (bus.pop),
        .recover       (bus.recover),
        .recover_ptr   (bus.recover_ptr),
        .recover_count (bus.recover_count),
        .ptr_q         (ptr_q),
        .count_q       (count_q),
        .overflow_q    (overflow_q),
        .ptr_d         (ptr_d),
        .count_d       (count_d),
        .overflow_d    (overflow_d),
        .wr_en         (wr_en),
        .wr_idx        (wr_idx)
    );

    always_comb begin
        wr_data = bus.recover ? bus.recover_top : bus.push_addr;
        stack_d = stack_q;
        if (wr_en) stack_d[wr_idx] = wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q      <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
        end else begin
            ptr_q      <= ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            stack_q    <= stack_d;
        end
    end

    // Stale entries are never cleared, so an empty stack must mask the read.
    always_comb begin
        bus.top_valid  = (count_q != '0);
        bus.top_addr   = bus.top_valid ? stack_q[ptr_q] : '0;
        bus.ckpt_ptr   = ptr_q;
        bus.ckpt_count = count_q;
        bus.ckpt_top   = stack_q[ptr_q];
        bus.overflow   = overflow_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_ras_ckpt.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ras_ckpt                                                              |
// | Directed scenarios plus randomized traffic against a stack model.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_ras_ckpt;
    localparam int D = 4;
    localparam int AW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    ras_ckpt_if #(.DEPTH(D), .ADDR_W(AW)) bus ();
    ras_ckpt #(.DEPTH(D), .ADDR_W(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    always #5 clk = ~clk;

    // Reference model: a circular array indexed by an integer top pointer.
    logic [AW-1:0] m_stk [D];
    int            m_ptr = 0;
    int            m_cnt = 0;
    bit            m_ovf = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ptr = 0; m_cnt = 0; m_ovf = 1'b0;
            for (int i = 0; i < D; i++) m_stk[i] = '0;
        end else if (bus.recover) begin
            m_ptr = int'(bus.recover_ptr);
            m_cnt = (int'(bus.recover_count) > D) ? D : int'(bus.recover_count);
            m_stk[m_ptr] = bus.recover_top;
            m_ovf = 1'b0;
        end else if (bus.push && bus.pop) begin
            m_stk[m_ptr] = bus.push_addr;
            if (m_cnt == 0) m_cnt = 1;
        end else if (bus.push) begin
            m_ptr = (m_ptr + 1) % D;
            m_stk[m_ptr] = bus.push_addr;
            if (m_cnt == D) m_ovf = 1'b1;
            else            m_cnt = m_cnt + 1;
        end else if (bus.pop && m_cnt > 0) begin
            m_ptr = (m_ptr + D - 1) % D;
            m_cnt = m_cnt - 1;
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("mdl_top_valid", 64'(bus.top_valid), 64'(m_cnt != 0));
            check("mdl_top_addr", 64'(bus.top_addr), (m_cnt != 0) ? 64'(m_stk[m_ptr]) : 64'd0);
            check("mdl_ckpt_ptr", 64'(bus.ckpt_ptr), 64'(m_ptr));
            check("mdl_ckpt_count", 64'(bus.ckpt_count), 64'(m_cnt));
            check("mdl_ckpt_top", 64'(bus.ckpt_top), 64'(m_stk[m_ptr]));
            check("mdl_overflow", 64'(bus.overflow), 64'(m_ovf));
        end
    end

    task automatic do_op(input bit p, input bit q, input logic [AW-1:0] a);
        bus.push = p; bus.pop = q; bus.push_addr = a;
        @(posedge clk); #1;
        bus.push = 1'b0; bus.pop = 1'b0;
    endtask

    task automatic do_recover(input int rp, input int rc, input logic [AW-1:0] rt);
        bus.recover = 1'b1;
        bus.recover_ptr = 2'(rp); bus.recover_count = 3'(rc); bus.recover_top = rt;
        bus.push = 1'($urandom_range(0, 1)); bus.pop = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        bus.recover = 1'b0; bus.push = 1'b0; bus.pop = 1'b0;
    endtask

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic expect_state(input string nm, input logic [AW-1:0] top, input int v,
                                input int cnt);
        check({nm, "_top"}, 64'(bus.top_addr), 64'(top));
        check({nm, "_valid"}, 64'(bus.top_valid), 64'(v));
        check({nm, "_count"}, 64'(bus.ckpt_count), 64'(cnt));
    endtask

    initial begin
        logic [AW-1:0] pops_exp [3];
        pops_exp[0] = 32'h40; pops_exp[1] = 32'h30; pops_exp[2] = 32'h20;
        bus.push = 0; bus.pop = 0; bus.push_addr = '0; bus.recover = 0;
        bus.recover_ptr = '0; bus.recover_count = '0; bus.recover_top = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        expect_state("reset", 32'h0, 0, 0);
        check("reset_ptr", 64'(bus.ckpt_ptr), 64'd0);
        check("reset_ovf", 64'(bus.overflow), 64'd0);

        do_op(1, 0, 32'h100);
        expect_state("push1", 32'h100, 1, 1);
        check("push1_ptr", 64'(bus.ckpt_ptr), 64'd1);
        do_op(0, 1, '0);

        foreach (pops_exp[i]) do_op(1, 0, 32'h10 * (i + 1));
        do_op(1, 0, 32'h40);
        do_op(1, 0, 32'h50);
        expect_state("wrap", 32'h50, 1, 4);
        check("wrap_ovf", 64'(bus.overflow), 64'd1);
        for (int i = 0; i < 3; i++) begin
            do_op(0, 1, '0);
            check("wrap_pop_top", 64'(bus.top_addr), 64'(pops_exp[i]));
        end
        do_op(0, 1, '0);
        expect_state("wrap_empty", 32'h0, 0, 0);

        pulse_reset();
        for (int i = 0; i < 3; i++) begin
            do_op(0, 1, '0);
            expect_state("underflow", 32'h0, 0, 0);
            check("underflow_ptr", 64'(bus.ckpt_ptr), 64'd0);
        end

        do_op(1, 0, 32'h10);
        do_op(1, 0, 32'h20);
        do_op(1, 1, 32'h99);
        expect_state("pushpop", 32'h99, 1, 2);
        check("pushpop_ptr", 64'(bus.ckpt_ptr), 64'd2);
        do_op(0, 1, '0);
        check("pushpop_then_pop", 64'(bus.top_addr), 64'h10);

        pulse_reset();
        do_op(1, 0, 32'hA0);
        check("ckpt_ptr_rec", 64'(bus.ckpt_ptr), 64'd1);
        check("ckpt_cnt_rec", 64'(bus.ckpt_count), 64'd1);
        check("ckpt_top_rec", 64'(bus.ckpt_top), 64'hA0);
        do_op(0, 1, '0);
        do_op(1, 0, 32'hBB); do_op(1, 0, 32'hCC); do_op(1, 0, 32'hDD);
        do_op(1, 0, 32'hEE); do_op(1, 0, 32'hFF);
        check("pre_recover_ovf", 64'(bus.overflow), 64'd1);
        do_recover(1, 1, 32'hA0);
        expect_state("recover", 32'hA0, 1, 1);
        check("recover_ovf", 64'(bus.overflow), 64'd0);
        check("recover_ptr", 64'(bus.ckpt_ptr), 64'd1);
        do_recover(2, 7, 32'h5A);
        expect_state("recover_clamp", 32'h5A, 1, 4);

        pulse_reset();
        do_op(1, 0, 32'h1); do_op(1, 0, 32'h2); do_op(1, 0, 32'h3);
        #2 rst_n = 1'b0;
        #1;
        expect_state("async_rst", 32'h0, 0, 0);
        check("async_rst_ptr", 64'(bus.ckpt_ptr), 64'd0);
        check("async_rst_ckpt_top", 64'(bus.ckpt_top), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        do_op(1, 0, 32'h77);
        expect_state("post_rst_push", 32'h77, 1, 1);
        check("post_rst_ptr", 64'(bus.ckpt_ptr), 64'd1);

        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 99) < 5)
                do_recover(int'($urandom_range(0, D - 1)), int'($urandom_range(0, 7)), $urandom);
            else
                do_op($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 45, $urandom);
        end
        @(negedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
